// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register offsets, CTRL fields,
// counting modes and the per-channel state encoding.
package timer_bank_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PSC_LSB  = 8;

  localparam logic [1:0] MODE_ONESHOT     = 2'b00;
  localparam logic [1:0] MODE_RELOAD      = 2'b01;
  localparam logic [1:0] MODE_PULSE       = 2'b10;
  localparam logic [1:0] MODE_ONESHOT_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } chan_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler and
// the IDLE/LOAD/CNT/INT sequencer.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrl_be,
  input  logic [3:0]  preset_be,
  input  logic        status_we,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_off,
  output logic [31:0] rdata,
  output logic        irq
);

  chan_state_t      state, state_next;
  logic             en, en_next;
  logic [1:0]       mode, mode_next;
  logic             im, im_next;
  logic [7:0]       psc, psc_next;
  logic [7:0]       psc_cnt, psc_cnt_next;
  logic [WIDTH-1:0] preset, preset_next;
  logic [WIDTH-1:0] count, count_next;
  logic             pending, pending_next;
  logic             expire;
  logic [31:0]      pmask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      en      <= 1'b0;
      mode    <= 2'b00;
      im      <= 1'b0;
      psc     <= 8'd0;
      psc_cnt <= 8'd0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      en      <= en_next;
      mode    <= mode_next;
      im      <= im_next;
      psc     <= psc_next;
      psc_cnt <= psc_cnt_next;
      preset  <= preset_next;
      count   <= count_next;
      pending <= pending_next;
    end
  end

  // Sequencer first, then software writes on top so a CTRL write beats the
  // one-shot EN auto-clear; a new expiry beats a same-cycle W1C.
  always_comb begin
    state_next   = state;
    en_next      = en;
    mode_next    = mode;
    im_next      = im;
    psc_next     = psc;
    psc_cnt_next = psc_cnt;
    preset_next  = preset;
    count_next   = count;
    pending_next = pending;
    expire       = 1'b0;
    pmask        = byte_mask(preset_be);

    case (state)
      ST_IDLE: if (en) state_next = ST_LOAD;
      ST_LOAD: begin
        count_next   = preset;
        psc_cnt_next = 8'd0;
        state_next   = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (psc_cnt == psc) begin
          psc_cnt_next = 8'd0;
          if (count <= WIDTH'(1)) begin
            count_next = '0;
            expire     = 1'b1;
            state_next = ST_INT;
          end else begin
            count_next = count - WIDTH'(1);
          end
        end else begin
          psc_cnt_next = psc_cnt + 8'd1;
        end
      end
      ST_INT: begin
        case (mode)
          MODE_RELOAD: state_next = ST_LOAD;
          MODE_PULSE: begin
            pending_next = 1'b0;
            state_next   = ST_LOAD;
          end
          default: begin
            en_next    = 1'b0;
            state_next = ST_IDLE;
          end
        endcase
      end
      default: state_next = ST_IDLE;
    endcase

    if (ctrl_be[0]) begin
      en_next   = wdata[CTRL_EN];
      mode_next = wdata[CTRL_MODE_LSB +: 2];
      im_next   = wdata[CTRL_IM];
    end
    if (ctrl_be[1]) psc_next = wdata[CTRL_PSC_LSB +: 8];
    preset_next = (preset & ~pmask[WIDTH-1:0]) | (wdata[WIDTH-1:0] & pmask[WIDTH-1:0]);
    if (status_we && wdata[0]) pending_next = 1'b0;
    if (expire) pending_next = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (rd_off)
      OFF_CTRL:   rdata = {16'd0, psc, 4'd0, im, mode, en};
      OFF_PRESET: rdata = 32'(preset);
      OFF_COUNT:  rdata = 32'(count);
      default:    rdata = {31'd0, pending};
    endcase
  end

  assign irq = pending & im;

endmodule

// File: rtl/timer_bank.sv
// Bus-facing timer bank: address decode, per-channel byte-enable steering,
// read mux and interrupt aggregation around N_CH timer_channel instances.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [29:0]     addr,
  input  logic            we,
  input  logic [3:0]      byteen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            hit,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);

  localparam int          CW        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] SPAN      = 30'(4 * N_CH);

  logic [29:0]   rel;
  logic [CW-1:0] ch_sel;
  logic [1:0]    off;
  logic          wr;
  logic [31:0]   ch_rdata [N_CH];

  // Base is 16-byte aligned, so the low two word-address bits of the
  // offset pick the register and the next CW bits pick the channel.
  assign rel    = addr - BASE_WORD;
  assign hit    = (addr >= BASE_WORD) && (rel < SPAN);
  assign ch_sel = rel[CW+1:2];
  assign off    = rel[1:0];
  assign wr     = we & hit;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic       sel;
    logic [3:0] ctrl_be;
    logic [3:0] preset_be;
    logic       status_we;

    assign sel       = wr && (ch_sel == CW'(c));
    assign ctrl_be   = (sel && off == OFF_CTRL)   ? byteen : 4'b0000;
    assign preset_be = (sel && off == OFF_PRESET) ? byteen : 4'b0000;
    assign status_we = sel && (off == OFF_STATUS) && byteen[0];

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_be   (ctrl_be),
      .preset_be (preset_be),
      .status_we (status_we),
      .wdata     (wdata),
      .rd_off    (off),
      .rdata     (ch_rdata[c]),
      .irq       (irq[c])
    );
  end

  always_comb begin
    rdata = '0;
    if (hit) rdata = ch_rdata[ch_sel];
  end

  assign irq_any = |irq;

endmodule
